// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences the PE_array control inputs for one distance or dot-product vector-pair operation.
// Optional build macro PE_SEQ_PERF_EN adds the perf_cycles / perf_stalls counters.
module pe_seq_ctrl #(
  parameter int COL_STEPS  = 8,
  parameter int CHUNKS     = 2,
  parameter int SEL_W      = 8,
  parameter int SAVE_W     = 4,
  parameter int SETTLE_CYC = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         abort,
  input  logic                         data_valid,
  output logic                         load_en,
  output logic [$clog2(COL_STEPS)-1:0] col_index,
  output logic [$clog2(CHUNKS):0]      chunk_index,
  output logic [SEL_W-1:0]             sel_cu,
  output logic [SEL_W-1:0]             sel_cu_go_back,
  output logic [SEL_W-1:0]             sel_adder,
  output logic [SAVE_W-1:0]            is_save_cu_out,
  output logic [1:0]                   sum_row_pe,
  output logic [1:0]                   sum_column_pe,
  output logic                         busy,
  output logic                         chunk_done,
`ifdef PE_SEQ_PERF_EN
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stalls,
`endif
  output logic                         done
);

  localparam int CW  = $clog2(COL_STEPS);
  localparam int KW  = $clog2(CHUNKS) + 1;
  localparam int STW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CW-1:0]  COL_LAST    = CW'(COL_STEPS - 1);
  localparam logic [KW-1:0]  CHUNK_LAST  = KW'(CHUNKS - 1);
  localparam logic [STW-1:0] SETTLE_LOAD = STW'(SETTLE_CYC - 1);

  function automatic logic [SEL_W-1:0] alt_pat();
    logic [SEL_W-1:0] p;
    for (int unsigned i = 0; i < SEL_W; i++) p[i] = i[0];
    return p;
  endfunction

  localparam logic [SEL_W-1:0] ALT = alt_pat();
  localparam logic [SEL_W-1:0] ODD = ~ALT;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SAVE_P, S_SAVE_I, S_MUL, S_GUARD, S_ACC, S_MUL_D, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [KW-1:0]   chunk_q, chunk_d;
  logic [STW-1:0]  settle_q, settle_d;
  logic            mode_q, mode_d;
  logic            step_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      chunk_q  <= '0;
      settle_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      chunk_q  <= chunk_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    chunk_d        = chunk_q;
    settle_d       = settle_q;
    mode_d         = mode_q;
    step_end       = 1'b0;
    load_en        = 1'b0;
    sel_cu         = '0;
    sel_cu_go_back = '0;
    sel_adder      = '0;
    is_save_cu_out = '0;
    sum_row_pe     = 2'b10;
    sum_column_pe  = 2'b10;
    busy           = 1'b1;
    chunk_done     = 1'b0;
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy          = 1'b0;
        sum_row_pe    = 2'b00;
        sum_column_pe = 2'b00;
        if (start) begin
          mode_d  = mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = data_valid;
        if (data_valid) state_d = mode_q ? S_MUL_D : S_SAVE_P;
      end
      S_SAVE_P: begin
        is_save_cu_out = '1;
        sel_cu_go_back = ODD;
        state_d        = S_SAVE_I;
      end
      S_SAVE_I: begin
        is_save_cu_out = '1;
        sel_cu_go_back = '1;
        state_d        = S_MUL;
      end
      S_MUL: begin
        sel_cu         = '1;
        sel_cu_go_back = ALT;
        state_d        = S_GUARD;
      end
      // Adder stays closed one extra cycle after is_save drops.
      S_GUARD: begin
        sel_cu         = '1;
        sel_cu_go_back = ALT;
        settle_d       = SETTLE_LOAD;
        state_d        = S_ACC;
      end
      S_ACC: begin
        sel_cu         = '1;
        sel_cu_go_back = ALT;
        sel_adder      = ALT;
        if (settle_q == '0) step_end = 1'b1;
        else                settle_d = settle_q - STW'(1);
      end
      S_MUL_D: begin
        sel_cu         = ALT;
        sel_cu_go_back = ALT;
        sel_adder      = ALT;
        step_end       = 1'b1;
      end
      S_DONE: begin
        busy          = 1'b0;
        sum_row_pe    = 2'b00;
        sum_column_pe = 2'b00;
        done          = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (step_end) begin
      if (col_q == COL_LAST) begin
        chunk_done = 1'b1;
        col_d      = '0;
        if (chunk_q == CHUNK_LAST) begin
          chunk_d = '0;
          state_d = S_DONE;
        end else begin
          chunk_d = chunk_q + KW'(1);
          state_d = S_LOAD;
        end
      end else begin
        col_d   = col_q + CW'(1);
        state_d = S_LOAD;
      end
    end

    // Abort wins over a coincident step end and suppresses its chunk_done.
    if (abort && busy) begin
      state_d    = S_IDLE;
      col_d      = '0;
      chunk_d    = '0;
      chunk_done = 1'b0;
    end
  end

  assign col_index   = col_q;
  assign chunk_index = chunk_q;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] run_cyc_q, run_cyc_d, run_stl_q, run_stl_d;
  logic [31:0] perf_cyc_q, perf_cyc_d, perf_stl_q, perf_stl_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cyc_q  <= '0;
      run_stl_q  <= '0;
      perf_cyc_q <= '0;
      perf_stl_q <= '0;
    end else begin
      run_cyc_q  <= run_cyc_d;
      run_stl_q  <= run_stl_d;
      perf_cyc_q <= perf_cyc_d;
      perf_stl_q <= perf_stl_d;
    end
  end

  // Running counts include the current cycle, so they are published as the FSM enters DONE.
  always_comb begin
    run_cyc_d  = '0;
    run_stl_d  = '0;
    perf_cyc_d = perf_cyc_q;
    perf_stl_d = perf_stl_q;
    if (busy) begin
      run_cyc_d = (&run_cyc_q) ? run_cyc_q : run_cyc_q + 32'd1;
      run_stl_d = run_stl_q;
      if (state_q == S_LOAD && !data_valid && !(&run_stl_q)) run_stl_d = run_stl_q + 32'd1;
    end
    if (state_d == S_DONE) begin
      perf_cyc_d = run_cyc_d;
      perf_stl_d = run_stl_d;
    end
  end

  assign perf_cycles = perf_cyc_q;
  assign perf_stalls = perf_stl_q;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: scoreboarded load sequence and chunk_done timing per scenario.
module tb_pe_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, mode = 1'b0, abort = 1'b0, dv = 1'b1, start2 = 1'b0;

  always #5 clk = ~clk;

  logic       load_en, busy, chunk_done, done;
  logic [2:0] col;
  logic [1:0] chunk;
  logic [7:0] sel_cu, gb, adder;
  logic [3:0] is_save;
  logic [1:0] srow, scol;

  logic       ld2, busy2, cd2, done2;
  logic [1:0] col2;
  logic [2:0] chunk2;
  logic [7:0] sc2, gb2, ad2;
  logic [3:0] is2;
  logic [1:0] sr2, scl2;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] pc, ps, pc2, ps2;
`endif

  pe_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .data_valid(dv),
    .load_en(load_en), .col_index(col), .chunk_index(chunk),
    .sel_cu(sel_cu), .sel_cu_go_back(gb), .sel_adder(adder), .is_save_cu_out(is_save),
    .sum_row_pe(srow), .sum_column_pe(scol), .busy(busy), .chunk_done(chunk_done),
`ifdef PE_SEQ_PERF_EN
    .perf_cycles(pc), .perf_stalls(ps),
`endif
    .done(done)
  );

  pe_seq_ctrl #(.COL_STEPS(4), .CHUNKS(3), .SETTLE_CYC(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .mode(1'b0), .abort(abort), .data_valid(dv),
    .load_en(ld2), .col_index(col2), .chunk_index(chunk2),
    .sel_cu(sc2), .sel_cu_go_back(gb2), .sel_adder(ad2), .is_save_cu_out(is2),
    .sum_row_pe(sr2), .sum_column_pe(scl2), .busy(busy2), .chunk_done(cd2),
`ifdef PE_SEQ_PERF_EN
    .perf_cycles(pc2), .perf_stalls(ps2),
`endif
    .done(done2)
  );

  int total = 0, bad = 0;
  int busy_cnt, done_cnt, done_c, last_busy_c, load_cnt, acc_aa, savep, muld, stall_bad, post_busy, abort_c;
  int cd_at[$];
  int obs_ld[$];
  int exp_ld[$];
  int exp_cd[$];
  logic [63:0] snap;
  int e, o;

  function automatic logic [63:0] outs();
    return {23'd0, load_en, col, chunk, sel_cu, gb, adder, is_save, srow, scol, busy, chunk_done, done};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_loads(input int chunks_n, input int last_col_of_last);
    for (int k = 0; k < chunks_n; k++)
      for (int c = 0; c < 8; c++)
        if (k < chunks_n - 1 || c <= last_col_of_last) exp_ld.push_back(k * 256 + c);
  endtask

  // Drives one operation and records what the DUT produced; checks live in the test tasks.
  task automatic run_op(input logic m, input int stall_len, input bit do_abort, input bit noise);
    int stall_left, end_c;
    bit aborted;
    stall_left = stall_len; end_c = -1; aborted = 0;
    busy_cnt = 0; done_cnt = 0; done_c = -1; last_busy_c = -1; load_cnt = 0; acc_aa = 0;
    savep = 0; muld = 0; stall_bad = 0; post_busy = 0; abort_c = -1; snap = '1;
    cd_at.delete(); obs_ld.delete();
    start = 1'b1; mode = m; abort = 1'b0; dv = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      dv = 1'b1; abort = 1'b0; start = 1'b0;
      mode = noise ? (c % 2 == 1) : m;
      if (busy && is_save == 4'h0 && sel_cu == 8'h00 && col == 3'd2 && chunk == 2'd0 && stall_left > 0) begin
        dv = 1'b0; stall_left--;
      end
      if (noise && ((busy && c % 7 == 3) || done)) start = 1'b1;
      if (do_abort && !aborted && busy && chunk == 2'd1 && col == 3'd4 && adder == 8'hAA) begin
        abort = 1'b1; aborted = 1; abort_c = c;
      end
      #1;
      if (busy) begin
        busy_cnt++; last_busy_c = c;
        if (end_c >= 0) post_busy++;
      end
      if (!dv && (load_en || col != 3'd2)) stall_bad++;
      if (load_en) begin load_cnt++; obs_ld.push_back(int'(chunk) * 256 + int'(col)); end
      if (chunk_done) cd_at.push_back(busy_cnt);
      if (adder == 8'hAA && sel_cu == 8'hFF && gb == 8'hAA) acc_aa++;
      if (gb == 8'h55 && is_save == 4'hF && sel_cu == 8'h00 && adder == 8'h00) savep++;
      if (sel_cu == 8'hAA && gb == 8'hAA && adder == 8'hAA) muld++;
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
        if (end_c < 0) end_c = c + 3;
      end
      if (aborted && c == abort_c + 1) snap = outs();
      if (aborted && end_c < 0) end_c = abort_c + 4;
      if (end_c >= 0 && c >= end_c) break;
      @(posedge clk);
    end
    abort = 1'b0; start = 1'b0; dv = 1'b1; mode = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (outs() !== 64'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs()); end
    start = 1'b1;
    repeat (3) tick();
    total++; if (outs() !== 64'd0) begin bad++; $display("FAIL reset_hold_outs got=%h want=0", outs()); end
    start = 1'b0; rst = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy); end
`ifdef PE_SEQ_PERF_EN
    total++; if (pc !== 32'd0 || ps !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", pc, ps); end
`endif
  endtask

  task automatic test_distance();
    push_loads(2, 7);
    exp_cd.push_back(80); exp_cd.push_back(160);
    run_op(1'b0, 0, 0, 0);
    total++; if (busy_cnt !== 160) begin bad++; $display("FAIL dist_busy got=%0d want=160", busy_cnt); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL dist_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL dist_load_idx got=%0h want=%0h", o, e); end
    end
    total++; if (cd_at.size() !== exp_cd.size()) begin bad++; $display("FAIL dist_cd_count got=%0d want=%0d", cd_at.size(), exp_cd.size()); end
    while (exp_cd.size() > 0 && cd_at.size() > 0) begin
      e = exp_cd.pop_front(); o = cd_at.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL dist_cd_at got=%0d want=%0d", o, e); end
    end
    exp_ld.delete(); exp_cd.delete();
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL dist_done_width got=%0d want=1", done_cnt); end
    total++; if (done_c !== last_busy_c + 1) begin bad++; $display("FAIL dist_done_pos got=%0d want=%0d", done_c, last_busy_c + 1); end
    total++; if (savep !== 16) begin bad++; $display("FAIL dist_save_p got=%0d want=16", savep); end
    total++; if (acc_aa !== 80) begin bad++; $display("FAIL dist_acc_cycles got=%0d want=80", acc_aa); end
    total++; if (post_busy !== 0) begin bad++; $display("FAIL dist_post_busy got=%0d want=0", post_busy); end
`ifdef PE_SEQ_PERF_EN
    total++; if (pc !== 32'd160 || ps !== 32'd0) begin bad++; $display("FAIL dist_perf got=%0d/%0d want=160/0", pc, ps); end
`endif
  endtask

  task automatic test_dot();
    push_loads(2, 7);
    exp_cd.push_back(16); exp_cd.push_back(32);
    run_op(1'b1, 0, 0, 0);
    total++; if (busy_cnt !== 32) begin bad++; $display("FAIL dot_busy got=%0d want=32", busy_cnt); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL dot_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL dot_load_idx got=%0h want=%0h", o, e); end
    end
    while (exp_cd.size() > 0) begin
      e = exp_cd.pop_front(); o = (cd_at.size() > 0) ? cd_at.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL dot_cd_at got=%0d want=%0d", o, e); end
    end
    exp_ld.delete();
    total++; if (muld !== 16) begin bad++; $display("FAIL dot_mul_d_cycles got=%0d want=16", muld); end
    total++; if (acc_aa !== 0) begin bad++; $display("FAIL dot_acc_cycles got=%0d want=0", acc_aa); end
    total++; if (done_cnt !== 1 || done_c !== last_busy_c + 1) begin bad++; $display("FAIL dot_done got=%0d@%0d want=1@%0d", done_cnt, done_c, last_busy_c + 1); end
`ifdef PE_SEQ_PERF_EN
    total++; if (pc !== 32'd32 || ps !== 32'd0) begin bad++; $display("FAIL dot_perf got=%0d/%0d want=32/0", pc, ps); end
`endif
  endtask

  task automatic test_stall();
    push_loads(2, 7);
    exp_cd.push_back(83); exp_cd.push_back(163);
    run_op(1'b0, 3, 0, 0);
    total++; if (busy_cnt !== 163) begin bad++; $display("FAIL stall_busy got=%0d want=163", busy_cnt); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_held got=%0d want=0", stall_bad); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL stall_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL stall_load_idx got=%0h want=%0h", o, e); end
    end
    while (exp_cd.size() > 0) begin
      e = exp_cd.pop_front(); o = (cd_at.size() > 0) ? cd_at.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL stall_cd_at got=%0d want=%0d", o, e); end
    end
    exp_ld.delete();
`ifdef PE_SEQ_PERF_EN
    total++; if (pc !== 32'd163 || ps !== 32'd3) begin bad++; $display("FAIL stall_perf got=%0d/%0d want=163/3", pc, ps); end
`endif
  endtask

  task automatic test_abort();
    push_loads(2, 4);
    run_op(1'b0, 0, 1, 0);
    total++; if (abort_c < 0) begin bad++; $display("FAIL abort_reached got=%0d want>=0", abort_c); end
    total++; if (snap !== 64'd0) begin bad++; $display("FAIL abort_outs got=%h want=0", snap); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    total++; if (cd_at.size() !== 1) begin bad++; $display("FAIL abort_cd_count got=%0d want=1", cd_at.size()); end
    total++; if (post_busy !== 0) begin bad++; $display("FAIL abort_post_busy got=%0d want=0", post_busy); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL abort_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL abort_load_idx got=%0h want=%0h", o, e); end
    end
    exp_ld.delete();
`ifdef PE_SEQ_PERF_EN
    total++; if (pc !== 32'd163 || ps !== 32'd3) begin bad++; $display("FAIL abort_perf got=%0d/%0d want=163/3", pc, ps); end
`endif
    push_loads(2, 7);
    run_op(1'b1, 0, 0, 0);
    total++; if (busy_cnt !== 32) begin bad++; $display("FAIL restart_busy got=%0d want=32", busy_cnt); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL restart_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL restart_load_idx got=%0h want=%0h", o, e); end
    end
    exp_ld.delete();
  endtask

  task automatic test_back_to_back();
    push_loads(2, 7);
    exp_cd.push_back(80); exp_cd.push_back(160);
    run_op(1'b0, 0, 0, 1);
    total++; if (busy_cnt !== 160) begin bad++; $display("FAIL noise_busy got=%0d want=160", busy_cnt); end
    total++; if (savep !== 16 || acc_aa !== 80) begin bad++; $display("FAIL noise_patterns got=%0d/%0d want=16/80", savep, acc_aa); end
    total++; if (done_cnt !== 1 || post_busy !== 0) begin bad++; $display("FAIL noise_done got=%0d/%0d want=1/0", done_cnt, post_busy); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL noise_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL noise_load_idx got=%0h want=%0h", o, e); end
    end
    while (exp_cd.size() > 0) begin
      e = exp_cd.pop_front(); o = (cd_at.size() > 0) ? cd_at.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL noise_cd_at got=%0d want=%0d", o, e); end
    end
    exp_ld.delete();
  endtask

  task automatic test_async_reset();
    bit found;
    found = 0;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (is_save == 4'hF && gb == 8'hFF) begin found = 1; break; end
      tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rst_save_i_reached got=0 want=1"); end
    #1 rst = 1'b0;
    #1;
    total++; if (outs() !== 64'd0) begin bad++; $display("FAIL rst_async_outs got=%h want=0", outs()); end
    @(posedge clk); #4 rst = 1'b1;
    push_loads(2, 7);
    run_op(1'b0, 0, 0, 0);
    total++; if (busy_cnt !== 160) begin bad++; $display("FAIL rst_rerun_busy got=%0d want=160", busy_cnt); end
    total++; if (obs_ld.size() !== exp_ld.size()) begin bad++; $display("FAIL rst_rerun_loads got=%0d want=%0d", obs_ld.size(), exp_ld.size()); end
    while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
      e = exp_ld.pop_front(); o = obs_ld.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rst_rerun_load_idx got=%0h want=%0h", o, e); end
    end
    exp_ld.delete();
  endtask

  task automatic test_small_params();
    int nb, nld, ndone;
    int cd2_at[$];
    nb = 0; nld = 0; ndone = 0;
    exp_cd.push_back(24); exp_cd.push_back(48); exp_cd.push_back(72);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy2) nb++;
      if (ld2) nld++;
      if (cd2) cd2_at.push_back(nb);
      if (done2) begin ndone++; break; end
      tick();
    end
    tick();
    total++; if (nb !== 72) begin bad++; $display("FAIL small_busy got=%0d want=72", nb); end
    total++; if (nld !== 12) begin bad++; $display("FAIL small_loads got=%0d want=12", nld); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL small_done got=%0d want=1", ndone); end
    while (exp_cd.size() > 0) begin
      e = exp_cd.pop_front(); o = (cd2_at.size() > 0) ? cd2_at.pop_front() : -1;
      total++; if (o !== e) begin bad++; $display("FAIL small_cd_at got=%0d want=%0d", o, e); end
    end
    total++;
    if ({ld2, col2, chunk2, sc2, gb2, ad2, is2, sr2, scl2, busy2, cd2, done2} !== 40'd0) begin
      bad++; $display("FAIL small_idle_outs got=%h want=0", {ld2, col2, chunk2, sc2, gb2, ad2, is2, sr2, scl2, busy2, cd2, done2});
    end
`ifdef PE_SEQ_PERF_EN
    total++; if (pc2 !== 32'd72 || ps2 !== 32'd0) begin bad++; $display("FAIL small_perf got=%0d/%0d want=72/0", pc2, ps2); end
`endif
  endtask

  initial begin
    test_reset();
    test_distance();
    test_dot();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_small_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
- Hardware sequencer that drives the PE_array control inputs for one vector-pair operation.
- Supports two modes: squared-distance (subtract, save, square, accumulate) and dot-product (multiply, accumulate).
- Iterates over COL_STEPS column steps per chunk and CHUNKS chunks per operation.
- Requests operand data from the MLB buffers through a valid handshake and signals chunk and operation completion to the downstream sort_relu stage.

Parameters:
- COL_STEPS, 8: column steps per chunk (must be ≥2, power of 2).
- CHUNKS, 2: chunks per operation (≥1).
- SEL_W, 8: width of sel_cu, sel_cu_go_back and sel_adder.
- SAVE_W, 4: width of is_save_cu_out.
- SETTLE_CYC, 5: accumulate-settle cycles after each distance step (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin operation (1-cycle pulse, sampled only in IDLE)
- mode  in  1  0 = distance, 1 = dot product; sampled with start
- abort  in  1  cancel current operation
- data_valid  in  1  MLB operands for current col_index/chunk_index are present
- load_en  out  1  strobe: PE in/par registers take the MLB data this cycle
- col_index  out  $clog2(COL_STEPS)  current column step
- chunk_index  out  $clog2(CHUNKS)+1  current chunk
- sel_cu  out  SEL_W  CU op select
- sel_cu_go_back  out  SEL_W  CU result routing
- sel_adder  out  SEL_W  adder tree enable
- is_save_cu_out  out  SAVE_W  write CU result back to in/par
- sum_row_pe  out  2  row reduce mode
- sum_column_pe  out  2  column reduce mode
- busy  out  1  operation in progress
- chunk_done  out  1  1-cycle pulse when a chunk's last step completes
- done  out  1  1-cycle pulse at end of operation

Behaviour:
- Bit patterns:
  - ALT = SEL_W-bit repeat of "10" (8'b10101010).
  - ODD = repeat of "01".
  - ONES = all 1s.
  - ZERO = all 0s.
- Reset (rst=0, async): state IDLE; all outputs 0, including counters, busy, pulses and load_en.
- IDLE:
  - All select outputs ZERO; sum_row_pe and sum_column_pe are 2'b00.
  - start=1 latches mode and moves to LOAD; busy=1 from the next cycle.
  - While busy, sum_row_pe and sum_column_pe are 2'b10.
- LOAD (both modes):
  - Outputs: col_index = step counter; sel_cu, sel_cu_go_back, sel_adder = ZERO; is_save_cu_out = 0.
  - load_en = data_valid. If data_valid=0, stay in LOAD with outputs held (stall, no timeout).
  - On data_valid=1: distance mode goes to SAVE_P; dot mode goes to MUL_D.
- Distance path, one cycle per state unless noted:
  - SAVE_P: is_save = all 1s, go_back = ODD, sel_cu = ZERO, adder = ZERO.
  - SAVE_I: is_save = all 1s, go_back = ONES.
  - MUL: is_save = 0, sel_cu = ONES, go_back = ALT, adder = ZERO.
  - GUARD: same outputs as MUL. This keeps the adder closed for one cycle after is_save drops.
  - ACC: sel_cu = ONES, go_back = ALT, adder = ALT. Held for SETTLE_CYC cycles via a down-counter, then the step ends.
  - Step length = 1 + 4 + SETTLE_CYC cycles with no stall; 10 at defaults.
- Dot path:
  - MUL_D: sel_cu = go_back = adder = ALT for 1 cycle, then the step ends.
  - Step length = 2 cycles with no stall.
- Step end:
  - col_index increments.
  - On the last step (col_index = COL_STEPS-1): chunk_done pulses in the step-end cycle, col_index wraps to 0, chunk_index increments.
  - If chunk_index was CHUNKS-1: go to DONE; otherwise go to LOAD.
- DONE:
  - Single cycle: done=1, busy=0, outputs as in IDLE.
  - Next state IDLE. start in the DONE cycle is ignored.
- Ignored inputs:
  - start while busy is ignored.
  - mode changes mid-operation are ignored.
- abort=1 in any busy state:
  - Next cycle: IDLE with all outputs 0.
  - No done, no chunk_done.
  - Abort has priority over step end.
- Reset mid-operation: immediate return to reset values; the next start begins from col_index 0, chunk 0.
- Counters never exceed their bounds; no wrap artefacts into IDLE.

Optional Feature:
- Macro PE_SEQ_PERF_EN.
- When defined:
  - Adds output perf_cycles (32 bits): number of busy cycles of the last completed operation, stall cycles included.
  - Updated on done; saturates at 32'hFFFFFFFF.
  - Unchanged on abort; reset to 0.
  - Adds output perf_stalls (32 bits): LOAD cycles with data_valid=0, with the same rules.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Distance, defaults, data_valid tied 1, start pulse → busy for exactly 160 cycles; chunk_done at busy cycles 80 and 160; done 1 cycle after; load_en pulses 16 times; SAVE_P shows sel_cu_go_back = 8'h55; ACC shows sel_adder = 8'hAA for 5 cycles per step.
- Dot, defaults → busy for 32 cycles; col_index sequence 0..7,0..7; every MUL_D cycle sel_cu = sel_cu_go_back = sel_adder = 8'hAA; done pulse width 1.
- Stall: distance, data_valid low for 3 cycles at step 2 of chunk 0 → LOAD outputs held, col_index=2, load_en=0; busy total 163; perf_stalls=3 and perf_cycles=163 when PE_SEQ_PERF_EN is defined.
- abort asserted in ACC of chunk 1 step 4 → next cycle all outputs 0, busy=0, no done; a subsequent start restarts from col 0, chunk 0.
- start re-pulsed while busy, and mode toggled mid-operation → ignored; cycle count and patterns match the uninterrupted run.
- rst asserted asynchronously mid-SAVE_I → outputs 0 before the next clk edge; with COL_STEPS=4, CHUNKS=3, SETTLE_CYC=1, distance → busy for 72 cycles.
